muon_pulse_emulator: RTL
========================

Name: muon_pulse_emulator

Overview:
- Synthetic ADC sample source for bench and in-system self-test of the muon-decay trigger chain; the transmitter end of the ADC-sample-to-threshold-trigger path.
- Emits 14-bit unsigned samples on adc_clk: baseline plus a rectangular "muon" pulse, optionally followed after a programmable gap by a second "decay electron" pulse, repeated at a programmable period.
- Output is muxed in place of the real ADC channel A feeding the threshold trigger.

Parameters:
- WIDTH_W, 8, bit width of the pulse-width register.
- GAP_W, 16, bit width of the pulse-gap register.
- PERIOD_W, 24, bit width of the repetition-period register.
- TAIL_SHIFT, 4, tail decrement = amplitude >> TAIL_SHIFT, minimum 1 (used only with MUON_EMU_TAIL_EN).

Ports:
- adc_clk  in  1  sample clock; all logic on rising edge.
- adc_rstn  in  1  asynchronous, active-low reset.
- enable  in  1  free-running event generation while high.
- single_shot  in  1  one-cycle strobe; starts exactly one event when idle.
- double_en  in  1  1 = emit second (decay) pulse; 0 = single pulse per event.
- baseline  in  14  idle sample level.
- amplitude  in  14  pulse height above baseline.
- width  in  WIDTH_W  flat-top length in cycles.
- gap  in  GAP_W  cycles from end of pulse 1 to start of pulse 2.
- period  in  PERIOD_W  cycles from one event start to the next.
- dat_out  out  14  emulated ADC sample.
- pulse_mark  out  1  high for exactly the first flat-top sample of each pulse.
- busy  out  1  high while an event is in progress (not IDLE).
- event_cnt  out  16  count of completed events; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; dat_out = 0, pulse_mark = 0, busy = 0, event_cnt = 0, all counters 0.
- All outputs registered; dat_out reflects the state of the previous cycle (1-cycle latency).
- Shadow registers: baseline, amplitude, width, gap, period, double_en latched on the event-start cycle; input changes mid-event take effect at the next event.
- IDLE: dat_out = live baseline. Start when enable = 1 or single_shot = 1 -> P1 on next cycle.
- P1: dat_out = sat(baseline + amplitude), for max(width,1) cycles; pulse_mark on the first of them. Exit -> GAP if double_en, else HOLD.
- GAP: dat_out = baseline, for gap cycles; gap = 0 -> P2 immediately, giving a merged 2*width flat top with two pulse_mark strobes.
- P2: identical to P1. Exit -> HOLD.
- HOLD: dat_out = baseline until the period counter, started at event start, reaches period. event_cnt increments on the HOLD exit cycle.
- HOLD exit: enable = 1 -> P1; else -> IDLE.
- period <= event length: HOLD lasts 0 cycles; next P1 follows the last pulse cycle directly (no gap cycle).
- Saturation: baseline + amplitude computed 15-bit, clipped to 16383.
- enable dropped mid-event: current event completes, event_cnt increments, then IDLE.
- single_shot while busy: ignored. single_shot together with enable in IDLE: a single start.
- Reset mid-event: immediate return to reset values; no partial event_cnt update.

Optional Feature:
- Macro MUON_EMU_TAIL_EN.
- Defined:
  - After each flat top, the level above baseline decays linearly by step = max(amplitude >> TAIL_SHIFT, 1) per cycle until 0.
  - The tail overlaps GAP/HOLD.
  - P2 reloads the level to full amplitude.
  - dat_out = sat(baseline + level).
- Undefined: rectangular pulses only; no tail logic synthesized.

Test Plan:
- Reset with enable = 1 -> dat_out = 0, busy = 0, event_cnt = 0. After release: P1 starts 1 cycle later; first pulse sample 2 cycles after release.
- single_shot; baseline = 100, amplitude = 1000, width = 5, double_en = 0, period = 50 -> exactly one run of 5 samples at 1100 with one pulse_mark; event_cnt = 1 at cycle 50; then IDLE.
- enable = 1, double_en = 1, width = 4, gap = 10, period = 100 -> two 4-cycle pulses, rising edges 14 cycles apart; events repeat every 100 cycles; event_cnt = 3 after 300 cycles.
- baseline = 16000, amplitude = 1000 -> flat top = 16383; gap = 0 -> single 8-cycle flat top (width = 4) with 2 pulse_mark strobes.
- period = 3 with width = 4 and double_en = 0 -> back-to-back events with no baseline sample between. Drop enable mid-P1 -> event finishes, then IDLE.
- MUON_EMU_TAIL_EN, amplitude = 160, TAIL_SHIFT = 4 -> after the flat top, levels 150, 140, ... 0 over 16 cycles, then baseline.

Source files
------------

// File: rtl/muon_pulse_emulator.sv
// rtl/muon_pulse_emulator.sv - synthetic muon / decay-electron ADC sample source
//
// Emits baseline plus a rectangular muon pulse, optionally followed after a
// programmable gap by a second decay-electron pulse, repeated every period.
//
// Ports:
//   adc_clk      sample clock, rising edge
//   adc_rstn     asynchronous active-low reset
//   enable       free-running event generation while high
//   single_shot  one-cycle strobe, starts one event when idle
//   double_en    emit the second (decay) pulse
//   baseline     idle sample level
//   amplitude    pulse height above baseline
//   width        flat-top length in cycles (0 treated as 1)
//   gap          cycles from end of pulse 1 to start of pulse 2
//   period       cycles from one event start to the next
//   dat_out      emulated 14-bit ADC sample (registered)
//   pulse_mark   high on the first flat-top sample of each pulse
//   busy         event in progress
//   event_cnt    completed events, wraps
//
// Optional feature: define MUON_EMU_TAIL_EN for a linear decay tail after
// each flat top (step = max(amplitude >> TAIL_SHIFT, 1) per cycle).

module muon_pulse_emulator #(
    parameter int WIDTH_W    = 8,
    parameter int GAP_W      = 16,
    parameter int PERIOD_W   = 24,
    parameter int TAIL_SHIFT = 4
) (
    input  logic                adc_clk,
    input  logic                adc_rstn,
    input  logic                enable,
    input  logic                single_shot,
    input  logic                double_en,
    input  logic [13:0]         baseline,
    input  logic [13:0]         amplitude,
    input  logic [WIDTH_W-1:0]  width,
    input  logic [GAP_W-1:0]    gap,
    input  logic [PERIOD_W-1:0] period,
    output logic [13:0]         dat_out,
    output logic                pulse_mark,
    output logic                busy,
    output logic [15:0]         event_cnt
);

    localparam int CNT_W = (WIDTH_W > GAP_W) ? WIDTH_W : GAP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_GAP,
        S_P2,
        S_HOLD
    } state_t;

    state_t state, state_d;

    // Event parameters frozen at event start so mid-event edits wait for the next event.
    logic [13:0]         sh_base;
    logic [13:0]         sh_amp;
    logic [WIDTH_W-1:0]  sh_width;
    logic [GAP_W-1:0]    sh_gap;
    logic [PERIOD_W-1:0] sh_period;
    logic                sh_double;

    logic [CNT_W-1:0]    cnt;        // cycles spent in the current state
    logic [CNT_W-1:0]    w_ext;
    logic [CNT_W-1:0]    g_ext;
    logic [PERIOD_W-1:0] pcnt;       // cycles since event start, 1 on the first P1 cycle

    logic                start;
    logic                evt_done;
    logic                pulse_last;
    logic                gap_last;
    logic                period_hit;
    logic                in_pulse;
    logic [13:0]         level;
    logic [13:0]         base_sel;
    logic [14:0]         sum;
    logic [13:0]         dat_d;

    assign w_ext      = CNT_W'(sh_width);
    assign g_ext      = CNT_W'(sh_gap);
    assign pulse_last = (w_ext == '0) || (cnt == w_ext - CNT_W'(1));
    assign gap_last   = (cnt == g_ext - CNT_W'(1));
    assign period_hit = (pcnt >= sh_period);
    assign in_pulse   = (state == S_P1) || (state == S_P2);

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Event completion (evt_done) happens on the last pulse cycle when the
    // period has already elapsed, so short periods chain events with no gap.
    always_comb begin
        state_d  = state;
        start    = 1'b0;
        evt_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable || single_shot) begin
                    state_d = S_P1;
                    start   = 1'b1;
                end
            end
            S_P1: begin
                if (pulse_last) begin
                    if (sh_double) begin
                        state_d = (sh_gap == '0) ? S_P2 : S_GAP;
                    end else if (period_hit) begin
                        evt_done = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = S_P2;
                end
            end
            S_P2: begin
                if (pulse_last) begin
                    if (period_hit) begin
                        evt_done = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (period_hit) begin
                    evt_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (evt_done) begin
            if (enable) begin
                state_d = S_P1;
                start   = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign base_sel = (state == S_IDLE) ? baseline : sh_base;

`ifdef MUON_EMU_TAIL_EN
    logic [13:0] tail_q;
    logic [13:0] tail_step;
    logic [13:0] tail_src;

    assign tail_step = ((sh_amp >> TAIL_SHIFT) == 14'd0) ? 14'd1 : (sh_amp >> TAIL_SHIFT);
    // During a flat top the tail is primed one step below full amplitude so the
    // first post-pulse sample is already decayed; P2 restarts from full height.
    assign tail_src  = in_pulse ? sh_amp : tail_q;
    assign level     = in_pulse ? sh_amp : tail_q;

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            tail_q <= '0;
        end else begin
            tail_q <= (tail_src > tail_step) ? (tail_src - tail_step) : 14'd0;
        end
    end
`else
    assign level = in_pulse ? sh_amp : 14'd0;

    // TAIL_SHIFT only shapes the optional decay tail.
    if (TAIL_SHIFT > 13) begin : g_tail_step_pinned_to_one
    end
`endif

    assign sum   = {1'b0, base_sel} + {1'b0, level};
    assign dat_d = sum[14] ? 14'h3FFF : sum[13:0];

    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            dat_out    <= '0;
            pulse_mark <= 1'b0;
            busy       <= 1'b0;
            event_cnt  <= '0;
            cnt        <= '0;
            pcnt       <= '0;
            sh_base    <= '0;
            sh_amp     <= '0;
            sh_width   <= '0;
            sh_gap     <= '0;
            sh_period  <= '0;
            sh_double  <= 1'b0;
        end else begin
            dat_out    <= dat_d;
            pulse_mark <= in_pulse && (cnt == '0);
            busy       <= (state != S_IDLE);
            if (evt_done) begin
                event_cnt <= event_cnt + 16'd1;
            end
            if ((state_d != state) || start) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (start) begin
                pcnt      <= PERIOD_W'(1);
                sh_base   <= baseline;
                sh_amp    <= amplitude;
                sh_width  <= width;
                sh_gap    <= gap;
                sh_period <= period;
                sh_double <= double_en;
            end else if (state == S_IDLE) begin
                pcnt <= '0;
            end else if (pcnt != '1) begin
                pcnt <= pcnt + PERIOD_W'(1);
            end
        end
    end

endmodule
